// File: rtl/peripheral_bus_arbiter.sv
// Two-master req/ack arbiter and sequencer in front of the peripherals port.
// Optional access counters are built when PERIPH_ARB_STATS_EN is defined.
module peripheral_bus_arbiter #(
  parameter int ADDR_WIDTH   = 31,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0Req,
  input  logic                  m0Write,
  input  logic [ADDR_WIDTH-1:0] m0Address,
  input  logic [DATA_WIDTH-1:0] m0DataIn,
  output logic [DATA_WIDTH-1:0] m0DataOut,
  output logic                  m0Ack,
  input  logic                  m1Req,
  input  logic                  m1Write,
  input  logic [ADDR_WIDTH-1:0] m1Address,
  input  logic [DATA_WIDTH-1:0] m1DataIn,
  output logic [DATA_WIDTH-1:0] m1DataOut,
  output logic                  m1Ack,
  output logic                  periphReadEnable,
  output logic                  periphWriteEnable,
  output logic [ADDR_WIDTH-1:0] periphAddress,
  output logic [DATA_WIDTH-1:0] periphDataIn,
  input  logic [DATA_WIDTH-1:0] periphDataOut
`ifdef PERIPH_ARB_STATS_EN
  ,
  output logic [15:0]           m0AccessCount,
  output logic [15:0]           m1AccessCount
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  localparam logic [1:0] LATENCY = 2'(READ_LATENCY);

  state_t                state, next_state;
  logic                  grant;       // 0 = master 0, 1 = master 1
  logic                  last_grant;
  logic                  pick;
  logic                  any_req;
  logic                  ack;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [1:0]            cnt;

  // On a tie the master that was not served last wins.
  assign any_req = m0Req | m1Req;
  assign pick    = (m0Req && m1Req) ? ~last_grant : m1Req;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state        = state;
    periphReadEnable  = 1'b0;
    periphWriteEnable = 1'b0;
    ack               = 1'b0;
    unique case (state)
      S_IDLE:  if (any_req) next_state = S_ISSUE;
      S_ISSUE: begin
        periphWriteEnable = lat_write;
        periphReadEnable  = ~lat_write;
        next_state        = lat_write ? S_ACK : S_WAIT;
      end
      S_WAIT:  if (cnt == 2'd1) next_state = S_ACK;
      S_ACK: begin
        ack        = 1'b1;
        next_state = S_IDLE;
      end
    endcase
  end

  assign m0Ack         = ack & ~grant;
  assign m1Ack         = ack & grant;
  assign periphAddress = lat_addr;
  assign periphDataIn  = lat_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      cnt        <= '0;
      m0DataOut  <= '0;
      m1DataOut  <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (any_req) begin
          grant     <= pick;
          lat_write <= pick ? m1Write   : m0Write;
          lat_addr  <= pick ? m1Address : m0Address;
          lat_data  <= pick ? m1DataIn  : m0DataIn;
        end
        S_ISSUE: cnt <= LATENCY;
        S_WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            if (grant) m1DataOut <= periphDataOut;
            else       m0DataOut <= periphDataOut;
          end
        end
        S_ACK: last_grant <= grant;
      endcase
    end
  end

`ifdef PERIPH_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0AccessCount <= '0;
      m1AccessCount <= '0;
    end else begin
      if (m0Ack) m0AccessCount <= m0AccessCount + 16'd1;
      if (m1Ack) m1AccessCount <= m1AccessCount + 16'd1;
    end
  end
`else
  // No access counters in this build.
`endif

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed bench: a vector table of single-master transactions plus
// hand-written sequences for round-robin, async reset and early req drop.
module tb_peripheral_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0Req, m0Write, m1Req, m1Write;
  logic [30:0] m0Address, m1Address;
  logic [31:0] m0DataIn, m1DataIn, m0DataOut, m1DataOut;
  logic        m0Ack, m1Ack;
  logic        periphReadEnable, periphWriteEnable;
  logic [30:0] periphAddress;
  logic [31:0] periphDataIn;
  logic [31:0] periphDataOut = 32'hDEADBEEF;
`ifdef PERIPH_ARB_STATS_EN
  logic [15:0] m0AccessCount, m1AccessCount;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  peripheral_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0Req(m0Req), .m0Write(m0Write), .m0Address(m0Address),
    .m0DataIn(m0DataIn), .m0DataOut(m0DataOut), .m0Ack(m0Ack),
    .m1Req(m1Req), .m1Write(m1Write), .m1Address(m1Address),
    .m1DataIn(m1DataIn), .m1DataOut(m1DataOut), .m1Ack(m1Ack),
    .periphReadEnable(periphReadEnable), .periphWriteEnable(periphWriteEnable),
    .periphAddress(periphAddress), .periphDataIn(periphDataIn),
    .periphDataOut(periphDataOut)
`ifdef PERIPH_ARB_STATS_EN
    , .m0AccessCount(m0AccessCount), .m1AccessCount(m1AccessCount)
`endif
  );

  always #5 clk = ~clk;

  // Peripheral read data: address-dependent one cycle after readEnable, junk otherwise.
  function automatic logic [31:0] periph_f(input logic [30:0] a);
    return {a[15:0], 16'h0000} | {25'h0, a[30:24]};
  endfunction

  always @(posedge clk)
    periphDataOut <= periphReadEnable ? periph_f(periphAddress) : 32'hDEADBEEF;

  // Enable/ack monitor
  int          en_total = 0;
  int          viol = 0;
  logic        en_we;
  logic [30:0] en_addr;
  logic [31:0] en_data;

  always @(negedge clk) begin
    if (periphReadEnable || periphWriteEnable) begin
      en_total <= en_total + 1;
      en_we    <= periphWriteEnable;
      en_addr  <= periphAddress;
      en_data  <= periphDataIn;
    end
    if ((periphReadEnable && periphWriteEnable) || (m0Ack && m1Ack))
      viol <= viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at the ack negedge with req dropped.
  task automatic run_txn(input logic m, input logic w, input logic [30:0] a,
                         input logic [31:0] d, output int lat);
    if (m) begin
      m1Req = 1'b1; m1Write = w; m1Address = a; m1DataIn = d;
    end else begin
      m0Req = 1'b1; m0Write = w; m0Address = a; m0DataIn = d;
    end
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (!(m ? m1Ack : m0Ack) && lat < 30);
    m0Req = 1'b0;
    m1Req = 1'b0;
  endtask

  typedef struct {
    logic        m;
    logic        w;
    logic [30:0] a;
    logic [31:0] d;
    int          lat;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[6];
  int   lat, en_before, n, cyc;
  int   order[4];
`ifdef PERIPH_ARB_STATS_EN
  logic [15:0] c0;
`endif

  initial begin
    vecs[0] = '{1'b0, 1'b1, 31'h0000004,  32'h0000002A, 3, 32'h00000000, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 31'h1000000,  32'h00000000, 4, 32'h00000000, 32'h00000001};
    vecs[2] = '{1'b0, 1'b0, 31'h0000123,  32'h00000000, 4, 32'h01230000, 32'h00000001};
    vecs[3] = '{1'b1, 1'b1, 31'h00ABCDE,  32'h000055AA, 3, 32'h01230000, 32'h00000001};
    vecs[4] = '{1'b0, 1'b1, 31'h7FFFFFFF, 32'hFFFFFFFF, 3, 32'h01230000, 32'h00000001};
    vecs[5] = '{1'b1, 1'b0, 31'h7FFFFFFF, 32'h00000000, 4, 32'h01230000, 32'hFFFF007F};

    {m0Req, m0Write, m1Req, m1Write} = '0;
    m0Address = '0; m1Address = '0; m0DataIn = '0; m1DataIn = '0;
    do_reset();

    check("reset_ctl", {28'h0, m0Ack, m1Ack, periphReadEnable, periphWriteEnable}, 32'h0);
    check("reset_addr", {1'b0, periphAddress}, 32'h0);
    check("reset_pdin", periphDataIn, 32'h0);
    check("reset_m0dout", m0DataOut, 32'h0);
    check("reset_m1dout", m1DataOut, 32'h0);

    for (int i = 0; i < 6; i++) begin
      en_before = en_total;
      run_txn(vecs[i].m, vecs[i].w, vecs[i].a, vecs[i].d, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_en_count", i), en_total - en_before, 1);
      check($sformatf("v%0d_en_write", i), {31'h0, en_we}, {31'h0, vecs[i].w});
      check($sformatf("v%0d_en_addr", i), {1'b0, en_addr}, {1'b0, vecs[i].a});
      check($sformatf("v%0d_en_data", i), en_data, vecs[i].d);
      check($sformatf("v%0d_m0dout", i), m0DataOut, vecs[i].e0);
      check($sformatf("v%0d_m1dout", i), m1DataOut, vecs[i].e1);
      @(negedge clk);
      check($sformatf("v%0d_ack_width", i), {30'h0, m0Ack, m1Ack}, 32'h0);
    end

    // Both masters held: strict alternation starting with m0.
    do_reset();
    en_before = en_total;
    order = '{2, 2, 2, 2};
    m0Req = 1'b1; m0Write = 1'b1; m0Address = 31'h10; m0DataIn = 32'h100;
    m1Req = 1'b1; m1Write = 1'b1; m1Address = 31'h20; m1DataIn = 32'h200;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (m0Ack && n < 4) begin order[n] = 0; n++; end
      if (m1Ack && n < 4) begin order[n] = 1; n++; end
    end
    m0Req = 1'b0; m1Req = 1'b0;
    check("rr_txn_count", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), order[i], i % 2);
    check("rr_en_count", en_total - en_before, 4);
    @(negedge clk);

    // Async reset during WAIT: m0 served last, so only reset makes m0 win the next tie.
    run_txn(1'b1, 1'b0, 31'h7FFFFFFF, 32'h0, lat);
    check("pre_rst_m1dout", m1DataOut, 32'hFFFF007F);
    @(negedge clk);
    run_txn(1'b0, 1'b1, 31'h30, 32'h3, lat);
    @(negedge clk);
    m1Req = 1'b1; m1Write = 1'b0; m1Address = 31'h1000000;
    @(negedge clk);
    check("abort_issue_re", {31'h0, periphReadEnable}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ctl", {28'h0, m0Ack, m1Ack, periphReadEnable, periphWriteEnable}, 32'h0);
    check("abort_m0dout", m0DataOut, 32'h0);
    check("abort_m1dout", m1DataOut, 32'h0);
    m1Req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {29'h0, m0Ack, m1Ack, periphReadEnable}, 32'h0);
    check("post_rst_m1dout", m1DataOut, 32'h0);
    m0Req = 1'b1; m0Write = 1'b1; m0Address = 31'h40;
    m1Req = 1'b1; m1Write = 1'b1; m1Address = 31'h50;
    cyc = 0;
    while (!m0Ack && !m1Ack && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    m0Req = 1'b0; m1Req = 1'b0;
    check("post_rst_tie", {30'h0, m0Ack, m1Ack}, 32'h2);
    @(negedge clk);

    // m0 drops req during ISSUE; the latched write must still complete.
`ifdef PERIPH_ARB_STATS_EN
    c0 = m0AccessCount;
`endif
    en_before = en_total;
    m0Req = 1'b1; m0Write = 1'b1; m0Address = 31'h2000000; m0DataIn = 32'hCAFE;
    lat = 1;
    @(negedge clk);
    lat++;
    check("drop_issue_we", {31'h0, periphWriteEnable}, 32'h1);
    m0Req = 1'b0;
    while (!m0Ack && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("drop_latency", lat, 3);
    check("drop_en_count", en_total - en_before, 1);
    check("drop_en_addr", {1'b0, en_addr}, 32'h2000000);
    check("drop_en_data", en_data, 32'hCAFE);
    @(negedge clk);
`ifdef PERIPH_ARB_STATS_EN
    check("stats_m0_inc", {16'h0, m0AccessCount}, {16'h0, c0 + 16'd1});
`endif
    check("drop_no_restart", {31'h0, periphWriteEnable | periphReadEnable}, 32'h0);

    check("overlap_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
